// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO word packer.
//   packer_state_t : packer FSM states (S_FILL accumulating, S_OUT beat held)
//   KEEP_MAX       : widest lane-keep mask keep_mask() can build (ratio must not exceed it)
//   keep_mask(n)   : mask with the n low bits set
package fifo_pkg;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_OUT  = 1'b1
  } packer_state_t;

  localparam int KEEP_MAX = 32;

  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned count);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (i < count) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bus bundle between the packer, its upstream FIFO and its downstream consumer.
//   fifo_empty / fifo_read_data / fifo_pop : FIFO drain side
//   flush                                  : single-cycle partial-beat request
//   out_valid / out_ready / out_data / out_keep : wide beat output
//   dbg_state                              : packer FSM state, for observation
// Modports: master = the packer, slave = FIFO plus downstream consumer.
//
// Handshake: a beat transfers on a clock edge where out_valid and out_ready
// are both high. Once out_valid rises, out_data and out_keep stay stable and
// out_valid stays high until that transfer; out_ready may change freely and
// does not depend on out_valid. fifo_pop is a combinational strobe: the FIFO
// head in fifo_read_data is consumed on the edge where fifo_pop is high.
interface fifo_word_packer_if
  import fifo_pkg::*;
#(
  parameter int width = 8,
  parameter int ratio = 4
) ();

  logic                     fifo_empty;
  logic [width-1:0]         fifo_read_data;
  logic                     fifo_pop;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [width*ratio-1:0]   out_data;
  logic [ratio-1:0]         out_keep;
  packer_state_t            dbg_state;

  modport master (
    input  fifo_empty, fifo_read_data, flush, out_ready,
    output fifo_pop, out_valid, out_data, out_keep, dbg_state
  );

  modport slave (
    output fifo_empty, fifo_read_data, flush, out_ready,
    input  fifo_pop, out_valid, out_data, out_keep, dbg_state
  );

endinterface

// File: rtl/fifo_word_packer.sv
// Drains narrow words from a FIFO and packs `ratio` consecutive words into one
// wide beat (first word in lane 0). A flush emits the words gathered so far as
// a partial beat with a lane-keep mask; unused lanes read as zero.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (drops any partially packed words)
//   bus  : fifo_word_packer_if.master (FIFO drain, flush, beat output, dbg_state)
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int width = 8,
  parameter int ratio = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_word_packer_if.master bus
);

  localparam int count_w = $clog2(ratio + 1);

  packer_state_t            state, state_n;
  logic [count_w-1:0]       count, count_n, fill_count;
  logic [width*ratio-1:0]   staging, staging_n;
  logic [width*ratio-1:0]   beat_data, beat_data_n;
  logic [ratio-1:0]         beat_keep, beat_keep_n;
  logic                     flush_pending, flush_pending_n;
  logic                     accept, pop, fire;

  assign accept = (state == S_OUT) & bus.out_ready;
  // Popping in the accept cycle keeps the FIFO draining at full rate.
  assign pop    = !rst & !bus.fifo_empty & ((state == S_FILL) | accept);
  // Word count including the word being popped this cycle.
  assign fill_count = count + count_w'(pop);

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_data  = beat_data;
  assign bus.out_keep  = beat_keep;
  assign bus.dbg_state = state;

  always_comb begin
    state_n         = state;
    count_n         = count;
    staging_n       = staging;
    beat_data_n     = beat_data;
    beat_keep_n     = beat_keep;
    flush_pending_n = flush_pending;
    fire            = 1'b0;

    // count is always 0 in S_OUT, so an accept-cycle pop lands in lane 0.
    if (pop) staging_n[int'(count)*width +: width] = bus.fifo_read_data;

    case (state)
      S_FILL: begin
        // A deferred flush only fires if words were already staged when
        // the packer came back to S_FILL; otherwise it is dropped.
        fire = (fill_count == count_w'(ratio))
             | (bus.flush & (fill_count != '0))
             | (flush_pending & (count != '0));
        flush_pending_n = 1'b0;
        if (fire) begin
          // staging is cleared whenever a beat leaves, so lanes not written
          // since then are already zero.
          beat_data_n = staging_n;
          beat_keep_n = ratio'(keep_mask(32'(fill_count)));
          staging_n   = '0;
          count_n     = '0;
          state_n     = S_OUT;
        end else begin
          count_n = fill_count;
        end
      end
      S_OUT: begin
        if (bus.flush) flush_pending_n = 1'b1;
        if (accept) begin
          state_n = S_FILL;
          count_n = fill_count;
        end
      end
      default: state_n = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FILL;
      count         <= '0;
      staging       <= '0;
      beat_data     <= '0;
      beat_keep     <= '0;
      flush_pending <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      staging       <= staging_n;
      beat_data     <= beat_data_n;
      beat_keep     <= beat_keep_n;
      flush_pending <= flush_pending_n;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a queue-based FIFO feeds the packer, and a
// word-list model of the packing rules predicts pops and beats every cycle.
module tb_fifo_word_packer;
  import fifo_pkg::*;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int BW = W * R;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_word_packer_if #(.width(W), .ratio(R)) pif ();

  fifo_word_packer #(.width(W), .ratio(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.master)
  );

  // ---------------- FIFO, model, scoreboard ----------------
  logic [W-1:0]      fifo_q[$];
  logic [W-1:0]      m_stage[$];      // words packed but not yet emitted
  bit                m_pend;
  logic [BW+R-1:0]   exp_q[$];        // {keep, data} of the beat being offered
  logic [BW-1:0]     got_q[$];        // accepted beats, for literal checks
  logic [R-1:0]      got_keep_q[$];

  int checks = 0;
  int errors = 0;
  int pop_cnt, cur_streak, max_streak, valid_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    got_keep_q.delete();
    pop_cnt = 0; cur_streak = 0; max_streak = 0; valid_cycles = 0;
  endtask

  task automatic drive_fifo();
    pif.fifo_empty     = (fifo_q.size() == 0);
    pif.fifo_read_data = (fifo_q.size() == 0) ? W'($urandom) : fifo_q[0];
  endtask

  // One clock edge of the packing rules, expressed on word lists.
  task automatic model_edge(input bit r, input bit fl, input bit rdy, input bit pop,
                            input logic [W-1:0] w);
    int n0;
    logic [BW-1:0] d;
    logic [R-1:0]  k;
    if (r) begin
      m_stage.delete(); exp_q.delete(); m_pend = 0;
      return;
    end
    if (exp_q.size() > 0) begin
      if (fl) m_pend = 1;
      if (rdy) void'(exp_q.pop_front());
      if (pop) m_stage.push_back(w);
    end else begin
      n0 = m_stage.size();
      if (pop) m_stage.push_back(w);
      if (m_stage.size() == R || (fl && m_stage.size() > 0) || (m_pend && n0 > 0)) begin
        d = '0; k = '0;
        foreach (m_stage[i]) begin
          d = d | (BW'(m_stage[i]) << (W * i));
          k[i] = 1'b1;
        end
        exp_q.push_back({k, d});
        m_stage.delete();
      end
      m_pend = 0;
    end
  endtask

  // Called at a negedge: drive inputs, check pop, advance model, check outputs.
  task automatic step(input bit r, input bit fl, input bit rdy);
    logic          exp_pop;
    logic [W-1:0]  w;
    logic [BW+R-1:0] e;
    rst = r; pif.flush = fl; pif.out_ready = rdy;
    drive_fifo();
    #1;
    exp_pop = !r && fifo_q.size() > 0 && (exp_q.size() == 0 || rdy);
    check("fifo_pop", pif.fifo_pop, exp_pop);
    w = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    if (pif.out_valid) valid_cycles++;
    if (!r && pif.out_valid && rdy) begin
      got_q.push_back(pif.out_data);
      got_keep_q.push_back(pif.out_keep);
    end
    if (pif.fifo_pop) begin
      pop_cnt++; cur_streak++;
      if (cur_streak > max_streak) max_streak = cur_streak;
      check("no_underflow", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end else begin
      cur_streak = 0;
    end
    model_edge(r, fl, rdy, exp_pop, w);
    @(negedge clk);
    check("out_valid", pif.out_valid, exp_q.size() > 0);
    check("dbg_state", pif.dbg_state, (exp_q.size() > 0) ? S_OUT : S_FILL);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("out_data", pif.out_data, e[BW-1:0]);
      check("out_keep", pif.out_keep, e[BW+R-1:BW]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    rst = 1'b1; pif.flush = 1'b0; pif.out_ready = 1'b0;
    fifo_q.push_back(8'h5A);
    drive_fifo();
    @(negedge clk);
    step(1, 0, 0);
    step(1, 0, 0);
    check("reset_out_data", pif.out_data, 0);
    check("reset_out_keep", pif.out_keep, 0);

    // single word then flush: one-lane beat
    clear_log();
    step(0, 0, 1);
    step(0, 1, 1);
    run(3);
    check("t0_beats", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("t0_data", got_q[0], 32'h0000005A);
      check("t0_keep", got_keep_q[0], 4'b0001);
    end

    // four words, one full beat
    clear_log();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run(8);
    check("t1_beats", got_q.size(), 1);
    check("t1_pops", pop_cnt, 4);
    check("t1_valid_cycles", valid_cycles, 1);
    if (got_q.size() > 0) begin
      check("t1_data", got_q[0], 32'h44332211);
      check("t1_keep", got_keep_q[0], 4'b1111);
    end

    // eight words back to back, no bubble at the beat boundary
    clear_log();
    fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run(12);
    check("t2_streak", max_streak, 8);
    check("t2_beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t2_data0", got_q[0], 32'h04030201);
      check("t2_data1", got_q[1], 32'h08070605);
    end

    // same eight words with a 5-cycle stall on the first beat
    clear_log();
    fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 20 && !pif.out_valid; i++) step(0, 0, 0);
    check("t3_first_valid", pif.out_valid, 1);
    snap = pop_cnt;
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    check("t3_stall_pops", pop_cnt - snap, 0);
    step(0, 0, 1);
    check("t3_accept_pop", pop_cnt - snap, 1);
    run(10);
    check("t3_beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t3_data0", got_q[0], 32'h04030201);
      check("t3_data1", got_q[1], 32'h08070605);
    end

    // partial beat on flush, then a flush with nothing staged
    clear_log();
    fifo_q = '{8'hAA, 8'hBB};
    step(0, 0, 1); step(0, 0, 1);
    step(0, 1, 1);
    run(4);
    check("t4_beats", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("t4_data", got_q[0], 32'h0000BBAA);
      check("t4_keep", got_keep_q[0], 4'b0011);
    end
    clear_log();
    step(0, 1, 1);
    run(4);
    check("t4_empty_flush_beats", got_q.size(), 0);

    // flush coinciding with the fourth pop: full beat only
    clear_log();
    fifo_q = '{8'hAA, 8'hBB, 8'hCC};
    run(3);
    fifo_q.push_back(8'hDD);
    step(0, 1, 1);
    run(5);
    check("t5_beats", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("t5_data", got_q[0], 32'hDDCCBBAA);
      check("t5_keep", got_keep_q[0], 4'b1111);
    end

    // reset after two words: next beat realigns to lane 0
    clear_log();
    fifo_q = '{8'h01, 8'h02};
    run(2);
    step(1, 0, 1);
    check("t6_reset_valid", pif.out_valid, 0);
    fifo_q = '{8'h11, 8'h12, 8'h13, 8'h14};
    run(8);
    check("t6_beats", got_q.size(), 1);
    if (got_q.size() > 0) check("t6_data", got_q[0], 32'h14131211);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) fifo_q.push_back(W'($urandom));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
